// File: rtl/lvt_pkg.sv
// Shared parameter defaults and FSM encoding for the LVT port scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package lvt_pkg;

    localparam int unsigned LVT_P_DEF           = 4;
    localparam int unsigned LVT_PE_BITS_DEF     = 2;
    localparam int unsigned LVT_INDEX_WIDTH_DEF = 8;
    localparam int unsigned LVT_CONFLICT_CNT_W  = 16;

    // INIT clears the LVT by sweeping every index; RUN arbitrates requesters.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } lvt_state_e;

endpackage

// File: rtl/lvt_conflict_arbiter.sv
// Rotating-priority conflict filter: blocks a request when a higher-priority one hits the same address with a write.
// Latency: purely combinational.
// Backpressure: req_ready low on blocked ports; any_block flags that at least one valid port was held off.
module lvt_conflict_arbiter #(
    parameter int P           = 4,
    parameter int N_PE_BITS   = 2,
    parameter int INDEX_WIDTH = 8
) (
    input  logic [P-1:0]             req_valid,
    input  logic [P-1:0]             req_we,
    input  logic [P*INDEX_WIDTH-1:0] req_addr,
    input  logic [N_PE_BITS-1:0]     rr_ptr,
    output logic [P-1:0]             req_ready,
    output logic                     any_block
);

    logic [N_PE_BITS-1:0] rank [P];
    logic [P-1:0]         blocked;

    // Priority rank of each port relative to the round-robin pointer (0 = highest); wraps naturally since P is 2**N_PE_BITS.
    always_comb begin
        for (int i = 0; i < P; i++) begin
            rank[i] = N_PE_BITS'(i) - rr_ptr;
        end
    end

    // A port is blocked by any higher-ranked valid port on the same address when either side writes.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < P; i++) begin
            for (int j = 0; j < P; j++) begin
                if ((j != i) && req_valid[j] && (rank[j] < rank[i]) &&
                    (req_addr[j*INDEX_WIDTH +: INDEX_WIDTH] == req_addr[i*INDEX_WIDTH +: INDEX_WIDTH]) &&
                    (req_we[i] || req_we[j])) begin
                    blocked[i] = 1'b1;
                end
            end
        end
        req_ready = req_valid & ~blocked;
        any_block = |(req_valid & blocked);
    end

endmodule

// File: rtl/lvt_port_scheduler.sv
// Multi-port LVT scheduler: clears the table after reset, then issues non-conflicting requests with rotating priority.
// Latency: granted request appears on mem_* one cycle after the valid/ready handshake.
// Backpressure: req_ready is 0 during the clear sweep and for requests blocked by a higher-priority conflicting one.
module lvt_port_scheduler
    import lvt_pkg::*;
#(
    parameter int P           = LVT_P_DEF,
    parameter int N_PE_BITS   = LVT_PE_BITS_DEF,
    parameter int INDEX_WIDTH = LVT_INDEX_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [P-1:0]             req_valid,
    input  logic [P-1:0]             req_we,
    input  logic [P*INDEX_WIDTH-1:0] req_addr,
    output logic [P-1:0]             req_ready,
    output logic [P*INDEX_WIDTH-1:0] mem_addr,
    output logic [P-1:0]             mem_w_en,
    output logic [P-1:0]             mem_r_en,
    output logic                     init_busy,
    output logic [15:0]              conflict_cnt
);

    lvt_state_e               state_q, state_d;
    logic [INDEX_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic [N_PE_BITS-1:0]     rr_ptr_q, rr_ptr_d;
    logic [P*INDEX_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [P-1:0]             mem_w_en_q, mem_w_en_d;
    logic [P-1:0]             mem_r_en_q, mem_r_en_d;
    logic [15:0]              conflict_cnt_q, conflict_cnt_d;

    logic         in_run;
    logic         init_last;
    logic [P-1:0] arb_ready;
    logic         arb_any_block;
    logic         run_block;

    lvt_conflict_arbiter #(
        .P           (P),
        .N_PE_BITS   (N_PE_BITS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_arb (
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .rr_ptr    (rr_ptr_q),
        .req_ready (arb_ready),
        .any_block (arb_any_block)
    );

    assign init_last = &init_cnt_q;

    // FSM state register: reset restarts the clear sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave INIT once the last index has been issued; RUN is terminal.
    always_comb begin
        state_d = state_q;
        if ((state_q == ST_INIT) && init_last) begin
            state_d = ST_RUN;
        end
    end

    // FSM outputs: grants and conflict accounting only exist in RUN.
    always_comb begin
        in_run    = (state_q == ST_RUN);
        init_busy = (state_q == ST_INIT);
        req_ready = in_run ? arb_ready : '0;
        run_block = in_run & arb_any_block;
    end

    // Datapath next values: sweep writes on port 0 in INIT, otherwise register granted requests.
    always_comb begin
        init_cnt_d     = init_cnt_q;
        rr_ptr_d       = rr_ptr_q;
        mem_addr_d     = mem_addr_q;
        mem_w_en_d     = '0;
        mem_r_en_d     = '0;
        conflict_cnt_d = conflict_cnt_q;
        if (!in_run) begin
            mem_w_en_d[0]                = 1'b1;
            mem_addr_d[0 +: INDEX_WIDTH] = init_cnt_q;
            if (!init_last) begin
                init_cnt_d = init_cnt_q + INDEX_WIDTH'(1);
            end
        end else begin
            for (int i = 0; i < P; i++) begin
                if (req_ready[i]) begin
                    mem_addr_d[i*INDEX_WIDTH +: INDEX_WIDTH] = req_addr[i*INDEX_WIDTH +: INDEX_WIDTH];
                    mem_w_en_d[i] = req_we[i];
                    mem_r_en_d[i] = ~req_we[i];
                end
            end
            // Rotating the pointer only on conflict bounds a held request's wait to P-1 conflict cycles.
            if (run_block) begin
                rr_ptr_d = rr_ptr_q + N_PE_BITS'(1);
                if (conflict_cnt_q != 16'hFFFF) begin
                    conflict_cnt_d = conflict_cnt_q + 16'd1;
                end
            end
        end
    end

    // Datapath registers: reset drops any in-flight issue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt_q     <= '0;
            rr_ptr_q       <= '0;
            mem_addr_q     <= '0;
            mem_w_en_q     <= '0;
            mem_r_en_q     <= '0;
            conflict_cnt_q <= '0;
        end else begin
            init_cnt_q     <= init_cnt_d;
            rr_ptr_q       <= rr_ptr_d;
            mem_addr_q     <= mem_addr_d;
            mem_w_en_q     <= mem_w_en_d;
            mem_r_en_q     <= mem_r_en_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_w_en     = mem_w_en_q;
    assign mem_r_en     = mem_r_en_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule
